// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and run-control state type for the fetch front end.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  function automatic logic is_syscall(input logic [31:0] ins);
    return (ins[31:26] == OP_RTYPE) && (ins[5:0] == FN_SYSCALL);
  endfunction

endpackage

// File: rtl/ifetch_unit_imem.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
module imem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: PC, next-PC selection, loadable instruction memory and run control.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] Load_addr,
  input  logic [31:0]                   Load_data,
  input  logic                          Start,
  input  logic                          Stall,
  input  logic                          Zero,
  input  logic [31:0]                   Rdata1,
  output logic [31:0]                   Ins,
  output logic [31:0]                   PC,
  output logic [31:0]                   PC4,
  output logic                          Valid,
  output logic                          Halted,
  output logic [31:0]                   Icount
);

  localparam int AW = $clog2(IMEM_DEPTH);

  state_t        state_p0;
  logic [31:0]   pc_p0;
  logic [31:0]   icount_p0;
  logic          valid_p0;
  logic          halted_p0;

  logic [31:0]   mem_rdata;
  logic [31:0]   pc4;
  logic [31:0]   next_pc;
  logic signed [31:0] br_off;
  logic [31:0]   br_tgt;
  logic [5:0]    opcode;
  logic [5:0]    funct;

  imem #(
    .DATA_W (32),
    .DEPTH  (IMEM_DEPTH),
    .AW     (AW)
  ) u_imem (
    .clk   (CLK),
    .we    (Load_en && (state_p0 == IDLE)),
    .waddr (Load_addr),
    .wdata (Load_data),
    .raddr (pc_p0[AW+1:2]),
    .rdata (mem_rdata)
  );

  // Outside RUN a NOP is presented so downstream stages cause no side effects.
  assign Ins    = (state_p0 == RUN) ? mem_rdata : NOP;
  assign opcode = Ins[31:26];
  assign funct  = Ins[5:0];
  assign pc4    = pc_p0 + 32'd4;

  always_comb begin
    br_off  = signed'({{14{Ins[15]}}, Ins[15:0], 2'b00});
    br_tgt  = pc4 + unsigned'(br_off);
    next_pc = pc4;
    if (opcode == OP_BEQ) begin
      if (Zero) next_pc = br_tgt;
    end else if (opcode == OP_BNE) begin
      if (!Zero) next_pc = br_tgt;
    end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
      next_pc = {pc4[31:28], Ins[25:0], 2'b00};
    end else if ((opcode == OP_RTYPE) && (funct == FN_JR)) begin
      next_pc = Rdata1 & 32'hFFFF_FFFC;
    end
  end

  // ---- stage p0: PC / run-control register boundary ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p0  <= IDLE;
      pc_p0     <= RESET_PC;
      icount_p0 <= '0;
      valid_p0  <= 1'b0;
      halted_p0 <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (Start) begin
            state_p0 <= RUN;
            valid_p0 <= 1'b1;
          end
        end
        RUN: begin
          if (!Stall) begin
            if (is_syscall(Ins)) begin
              state_p0  <= HALT;
              valid_p0  <= 1'b0;
              halted_p0 <= 1'b1;
            end else begin
              pc_p0     <= next_pc;
              icount_p0 <= icount_p0 + 32'd1;
            end
          end
        end
        HALT: begin
          state_p0 <= HALT;
        end
        default: begin
          state_p0  <= IDLE;
          valid_p0  <= 1'b0;
          halted_p0 <= 1'b0;
        end
      endcase
    end
  end

  assign PC     = pc_p0;
  assign PC4    = pc4;
  assign Valid  = valid_p0;
  assign Halted = halted_p0;
  assign Icount = icount_p0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: directed program scenarios plus randomized runs
// checked against an architectural model of fetch and run control.
module tb_ifetch_unit;
  import mips_pkg::*;

  localparam int          DEPTH = 16;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] RPC   = 32'h0000_0000;

  localparam logic [31:0] I_ADDI    = 32'h2021_0001;
  localparam logic [31:0] I_SYSCALL = 32'h0000_000C;
  localparam logic [31:0] I_JR      = 32'h03E0_0008;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld = 1'b0;
  logic [AW-1:0] la = '0;
  logic [31:0]   ldat = '0;
  logic          st = 1'b0;
  logic          stall = 1'b0;
  logic          zero = 1'b0;
  logic [31:0]   rd1 = '0;
  logic [31:0]   ins, pc, pc4, icount;
  logic          valid, halted;

  ifetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .CLK(clk), .RST(rst), .Load_en(ld), .Load_addr(la), .Load_data(ldat),
    .Start(st), .Stall(stall), .Zero(zero), .Rdata1(rd1),
    .Ins(ins), .PC(pc), .PC4(pc4), .Valid(valid), .Halted(halted), .Icount(icount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic [31:0] icount;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Architectural model: 0 = idle, 1 = running, 2 = halted.
  logic [31:0] mmem [DEPTH];
  logic [31:0] mpc;
  logic [31:0] mcnt;
  int          mst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_ins();
    return (mst == 1) ? mmem[(mpc / 4) % DEPTH] : 32'h0;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] cur, input logic [31:0] i,
                                         input logic z, input logic [31:0] r1);
    logic [31:0] nxt;
    int          off;
    int unsigned op;
    nxt = cur + 32'd4;
    op  = i / 32'h0400_0000;
    off = int'($signed(i[15:0])) * 4;
    if (op == 4) return z ? nxt + 32'(off) : nxt;
    if (op == 5) return !z ? nxt + 32'(off) : nxt;
    if (op == 2 || op == 3) return (nxt & 32'hF000_0000) + (i % 32'h0400_0000) * 4;
    if (op == 0 && (i % 64) == 8) return r1 - (r1 % 4);
    return nxt;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pc", pc, e.pc);
      check("ins", ins, e.ins);
      check("pc4", pc4, e.pc4);
      check("icount", icount, e.icount);
      check("valid", 32'(valid), 32'(e.valid));
      check("halted", 32'(halted), 32'(e.halted));
    end
  end

  // One clock: advance the model with the driven inputs, queue the expectation, then clock.
  task automatic tick();
    logic [31:0] cur;
    exp_t        e;
    cur = m_ins();
    if (rst) begin
      mst = 0; mpc = RPC; mcnt = 0;
    end else if (mst == 0) begin
      if (ld) mmem[la] = ldat;
      if (st) mst = 1;
    end else if (mst == 1 && !stall) begin
      if (cur[31:26] == 6'd0 && cur[5:0] == 6'd12) mst = 2;
      else begin
        mpc  = m_next(mpc, cur, zero, rd1);
        mcnt = mcnt + 1;
      end
    end
    e.pc = mpc; e.ins = m_ins(); e.pc4 = mpc + 32'd4; e.icount = mcnt;
    e.valid = (mst == 1); e.halted = (mst == 2);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
    st = 1'b0;
    ld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; zero = 1'b0; tick(); rst = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    ld = 1'b1; la = AW'(a); ldat = d; tick();
  endtask

  task automatic fill_addi();
    for (int i = 0; i < DEPTH; i++) load(i, I_ADDI);
  endtask

  task automatic start();
    st = 1'b1; tick();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 11);
    case (sel)
      0, 1, 2: return {6'h08, r[25:0]};
      3:       return {6'h04, r[25:16], 16'(int'($signed(r[3:0])))};
      4:       return {6'h05, r[25:16], 16'(int'($signed(r[3:0])))};
      5:       return {6'h02, r[25:0]};
      6:       return {6'h03, r[25:0]};
      7:       return {6'h00, r[25:6], 6'h08};
      8:       return I_SYSCALL;
      default: return {6'h00, r[25:6], 6'h20};
    endcase
  endfunction

  logic [31:0] br_ins [4];
  logic        br_z   [4];
  logic [31:0] br_exp [4];

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0;
    mst = 0; mpc = RPC; mcnt = 0;
    @(negedge clk); #1;

    // Reset state and program load
    do_reset();
    check("rst_pc", pc, RPC);
    check("rst_ins", ins, 32'h0);
    check("rst_pc4", pc4, RPC + 32'd4);
    fill_addi();
    load(2, I_SYSCALL);
    start();
    check("start_pc", pc, 32'h0);
    tick(); tick();
    check("step_pc8", pc, 32'h8);
    tick();
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", pc, 32'h8);
    check("halt_cnt", icount, 32'd2);
    tick(); tick();
    check("halt_hold_pc", pc, 32'h8);

    // Branches at 0x10, reached through a jump from 0
    br_ins[0] = 32'h1000_FFFC; br_z[0] = 1'b1; br_exp[0] = 32'h04;
    br_ins[1] = 32'h1000_FFFC; br_z[1] = 1'b0; br_exp[1] = 32'h14;
    br_ins[2] = 32'h1400_FFFC; br_z[2] = 1'b0; br_exp[2] = 32'h04;
    br_ins[3] = 32'h1400_FFFC; br_z[3] = 1'b1; br_exp[3] = 32'h14;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      fill_addi();
      load(0, 32'h0800_0004);
      load(4, br_ins[k]);
      start();
      tick();
      check("jump_0x10", pc, 32'h10);
      zero = br_z[k];
      tick();
      check("branch_tgt", pc, br_exp[k]);
      zero = 1'b0;
    end

    // j and jr
    do_reset();
    load(0, 32'h0800_0020);
    start(); tick();
    check("j_tgt", pc, 32'h80);
    do_reset();
    load(0, I_JR);
    rd1 = 32'h0000_0043;
    start(); tick();
    check("jr_tgt", pc, 32'h40);
    rd1 = 32'h0;

    // Stall in RUN and over a syscall
    do_reset();
    fill_addi();
    load(3, I_SYSCALL);
    start(); tick();
    stall = 1'b1;
    tick(); tick(); tick();
    check("stall_pc", pc, 32'h4);
    check("stall_cnt", icount, 32'd1);
    check("stall_ins", ins, I_ADDI);
    stall = 1'b0;
    tick(); tick();
    stall = 1'b1;
    tick(); tick();
    check("stall_sys_valid", 32'(valid), 32'd1);
    check("stall_sys_halted", 32'(halted), 32'd0);
    stall = 1'b0;
    tick();
    check("sys_halted", 32'(halted), 32'd1);
    check("sys_pc", pc, 32'hC);
    check("sys_cnt", icount, 32'd3);

    // Wrap, load ignored in RUN, reset mid-run
    do_reset();
    fill_addi();
    start();
    ld = 1'b1; la = '0; ldat = I_SYSCALL; tick();
    for (int i = 0; i < 15; i++) tick();
    check("wrap_pc", pc, 32'h40);
    check("wrap_ins", ins, I_ADDI);
    do_reset();
    start();
    for (int i = 0; i < 5; i++) tick();
    check("mid_cnt", icount, 32'd5);
    do_reset();
    check("mid_rst_pc", pc, RPC);
    check("mid_rst_cnt", icount, 32'd0);
    check("mid_rst_ins", ins, 32'h0);
    start();
    check("rerun_ins", ins, I_ADDI);

    // Load and Start in the same idle cycle
    do_reset();
    ld = 1'b1; la = '0; ldat = 32'h2042_0007; st = 1'b1; tick();
    check("ld_start_ins", ins, 32'h2042_0007);

    // Randomized programs and control
    for (int it = 0; it < 25; it++) begin
      do_reset();
      for (int i = 0; i < DEPTH; i++) load(i, rand_ins());
      for (int c = 0; c < 50; c++) begin
        rst   = ($urandom_range(0, 49) == 0);
        st    = ($urandom_range(0, 4) == 0);
        ld    = !rst && ($urandom_range(0, 7) == 0);
        la    = AW'($urandom);
        ldat  = rand_ins();
        stall = ($urandom_range(0, 3) == 0);
        zero  = 1'($urandom);
        rd1   = $urandom;
        tick();
        rst = 1'b0;
      end
    end

    stall = 1'b0;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch front end for the single-cycle MIPS datapath. It owns the program counter and a loadable instruction memory, and drives the 32-bit instruction word that the decode, execute and data-memory stages consume. Each cycle it computes the next PC from the current instruction, the execute stage's Zero flag and register operand 1. A small run-control FSM handles program loading, start and halt on `syscall`.

## Interface
- IMEM_DEPTH, 256: instruction memory depth in 32-bit words; power of two; AW = log2(IMEM_DEPTH).
- RESET_PC, 32'h0000_0000: PC value after reset; word-aligned.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous and active-high.
- Load_en  in  1  write one instruction word into memory; honoured in IDLE only.
- Load_addr  in  AW  word index for the load.
- Load_data  in  32  instruction word for the load.
- Start  in  1  single-cycle pulse; IDLE -> RUN.
- Stall  in  1  hold the PC; the current instruction is re-presented.
- Zero  in  1  execute-stage ALU zero flag for the current instruction.
- Rdata1  in  32  register operand 1 for the current instruction; `jr` target.
- Ins  out  32  current instruction; combinational.
- PC  out  32  current PC; registered.
- PC4  out  32  PC + 4; combinational; used as the `jal` link value.
- Valid  out  1  high only in RUN.
- Halted  out  1  high only in HALT.
- Icount  out  32  count of retired instructions.

## Operation
- FSM states are IDLE, RUN and HALT. Reset enters IDLE.
- IDLE:
  - Load_en writes Load_data into mem[Load_addr].
  - Start moves to RUN. If Load_en and Start arrive in the same cycle, the load is performed and the FSM enters RUN.
- RUN:
  - Load_en is ignored.
  - Start is ignored.
  - On a non-stalled cycle the PC takes next_pc and Icount increments.
- HALT:
  - Entered from RUN when Ins is `syscall` (opcode 0, funct 6'h0C) and Stall = 0.
  - The PC holds the `syscall` address and Icount does not count the `syscall`.
  - HALT is left only through RST.
- Ins = mem[PC[AW+1:2]] in RUN. In IDLE and HALT, Ins = 32'h0000_0000 (NOP) so that downstream stages perform no side effects.
- PC index wraps modulo IMEM_DEPTH; the full 32-bit PC is still reported.
- next_pc, evaluated in priority order:
  - opcode 6'h04 `beq`: Zero ? PC4 + (sext(Ins[15:0]) << 2) : PC4.
  - opcode 6'h05 `bne`: !Zero ? branch target : PC4.
  - opcode 6'h02 `j` / 6'h03 `jal`: {PC4[31:28], Ins[25:0], 2'b00}.
  - opcode 0, funct 6'h08 `jr`: {Rdata1[31:2], 2'b00}; a misaligned target is silently aligned.
  - otherwise: PC4.
- All additions are modulo 2^32; overflow wraps silently.
- Stall has priority over every PC update and over entry to HALT. A stalled `syscall` keeps the FSM in RUN.
- RST at any time, including mid-run:
  - PC = RESET_PC, state = IDLE, Icount = 0.
  - Memory contents are retained, so Start re-runs the loaded program.

## Timing
- Reset values: PC = RESET_PC, Icount = 0, Valid = 0, Halted = 0, Ins = 0, PC4 = RESET_PC + 4.
- Memory read is asynchronous: Ins is valid in the same cycle as PC. Zero and Rdata1 return combinationally within that cycle (single-cycle datapath).
- A memory write in IDLE is visible on the next cycle.
- Start sampled high at edge N: Valid = 1 and Ins = mem[RESET_PC] after edge N.
- A taken branch or jump in cycle N puts the target on PC after edge N; there is no delay slot.
- A `syscall` presented at edge N with Stall = 0 gives Halted = 1 and Valid = 0 after edge N.

## Structure
- Shared package `mips_pkg`:
  - opcode constants OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE;
  - funct constants FN_JR, FN_SYSCALL;
  - state type with values IDLE, RUN, HALT;
  - NOP constant.
- One sub-module `imem`: 1 write port (synchronous), 1 asynchronous read port, parameterised by depth. The PC, next-PC logic and FSM live in `ifetch_unit`.

## Test plan
- Load/start: load mem[0..2] = addi, addi, syscall; pulse Start -> PC steps 0, 4, 8; then Halted = 1, PC holds 8, Icount = 2.
- Branch: `beq` at PC 0x10 with imm = 16'hFFFC. Zero = 1 -> next PC 0x04. Zero = 0 -> next PC 0x14. Same case for `bne` with the opposite sense.
- Jumps: `j` with target field 26'h000_0020 at PC 0x0 -> PC 0x80. `jr` with Rdata1 = 32'h0000_0043 -> PC 0x40.
- Stall: hold Stall = 1 for 3 cycles during RUN -> PC and Ins unchanged, Icount unchanged. Stall over a `syscall` -> stays in RUN until Stall drops.
- Wrap/ignore: IMEM_DEPTH = 4 with straight-line code -> PC 0x10 fetches mem[0]. Load_en during RUN -> memory unchanged.
- Reset mid-run: RST at Icount = 5 -> PC = RESET_PC, Icount = 0, IDLE, Ins = 0. A following Start re-executes the program with memory intact.
